card_sprite_blitter: RTL and testbench

//  Upstream writer for the VGA framebuffer (image RAM of 640x480 palette indices, 9 bits each).
//  On command, copies one card sprite (palette indices) from a sprite ROM into the framebuffer at (dest_x, dest_y).

---
 rtl/card_sprite_blitter_pkg.sv | 9 +
 rtl/card_sprite_blitter_addr_gen.sv | 41 ++++
 rtl/card_sprite_blitter.sv | 120 ++++++++++++
 tb/tb_card_sprite_blitter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/card_sprite_blitter_pkg.sv
// card_sprite_blitter_pkg: framebuffer geometry, pixel format and blitter FSM states
package card_sprite_blitter_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W = 9;
  localparam int FB_ADDR_W = 19;
  localparam logic [PIX_W-1:0] TRANSPARENT = 9'h1FF;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;
endpackage

// File: rtl/card_sprite_blitter_addr_gen.sv
// card_sprite_blitter_addr_gen: sprite col/row walk and sprite ROM address
module card_sprite_blitter_addr_gen #(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 96,
  parameter int ROM_ADDR_W = 17,
  parameter int CW = 6,
  parameter int RW = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  adv,
  input  logic [3:0]            id,
  output logic [CW-1:0]         col,
  output logic [RW-1:0]         row,
  output logic                  last,
  output logic [ROM_ADDR_W-1:0] rom_addr
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic col_end;
  assign col_end = col_q == CW'(SPRITE_W - 1);
  assign last = col_end && row_q == RW'(SPRITE_H - 1);
  assign col = col_q;
  assign row = row_q;
  assign rom_addr = ROM_ADDR_W'(id) * ROM_ADDR_W'(SPRITE_W * SPRITE_H)
                  + ROM_ADDR_W'(row_q) * ROM_ADDR_W'(SPRITE_W) + ROM_ADDR_W'(col_q);
  always_comb begin
    col_d = load ? '0 : adv ? (col_end ? '0 : col_q + 1'b1) : col_q;
    row_d = load ? '0 : (adv && col_end) ? (last ? '0 : row_q + 1'b1) : row_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/card_sprite_blitter.sv
// card_sprite_blitter: copies one sprite from ROM into the framebuffer with
// transparency, screen clipping and write-ready stall handling.
module card_sprite_blitter
  import card_sprite_blitter_pkg::*;
#(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 96,
  parameter int ROM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            sprite_id,
  input  logic [9:0]            dest_x,
  input  logic [8:0]            dest_y,
  output logic                  busy,
  output logic                  done,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]      rom_data,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]      fb_data,
  output logic                  fb_wen,
  input  logic                  fb_ready
);
  localparam int CW = SPRITE_W > 1 ? $clog2(SPRITE_W) : 1;
  localparam int RW = SPRITE_H > 1 ? $clog2(SPRITE_H) : 1;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [3:0] id_q, id_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic v1_q, v1_d;
  logic [10:0] x1_q, x1_d;
  logic [9:0] y1_q, y1_d;
  logic held_q, held_d;
  logic [PIX_W-1:0] hold_q, hold_d, pix;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0] fb_data_q, fb_data_d;
  logic fb_wen_q, fb_wen_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic last, stall, adv, load, vis;
  card_sprite_blitter_addr_gen #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ROM_ADDR_W(ROM_ADDR_W), .CW(CW), .RW(RW)
  ) u_addr_gen (
    .clk(clk), .reset(reset), .load(load), .adv(adv), .id(id_q),
    .col(col), .row(row), .last(last), .rom_addr(rom_addr)
  );
  assign stall = fb_wen_q && !fb_ready;
  assign adv = state_q == RUN && !stall;
  assign load = state_q == IDLE && start;
  // The ROM keeps re-reading the next S0 address during a stall, so the S1 word is parked here
  assign pix = held_q ? hold_q : rom_data;
  assign vis = v1_q && pix != TRANSPARENT && x1_q < 11'(SCREEN_W) && y1_q < 10'(SCREEN_H);
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    id_d = load ? sprite_id : id_q;
    x_d = load ? dest_x : x_q;
    y_d = load ? dest_y : y_q;
    if (load) begin
      state_d = RUN;
      busy_d = 1'b1;
    end
    if (adv && last) state_d = DRAIN;
    if (state_q == DRAIN && !v1_q && !stall) begin
      state_d = FIN;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (state_q == FIN) state_d = IDLE;
    v1_d = stall ? v1_q : adv;
    x1_d = stall ? x1_q : {1'b0, x_q} + 11'(col);
    y1_d = stall ? y1_q : {1'b0, y_q} + 10'(row);
    held_d = stall;
    hold_d = (stall && !held_q) ? rom_data : hold_q;
    fb_wen_d = stall ? fb_wen_q : vis;
    fb_addr_d = (!stall && vis) ? FB_ADDR_W'(y1_q) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(x1_q) : fb_addr_q;
    fb_data_d = (!stall && vis) ? pix : fb_data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      id_q <= '0;
      x_q <= '0;
      y_q <= '0;
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      held_q <= 1'b0;
      hold_q <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_wen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      v1_q <= v1_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      held_q <= held_d;
      hold_q <= hold_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_wen_q <= fb_wen_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign fb_wen = fb_wen_q;
endmodule

// File: tb/tb_card_sprite_blitter.sv
// tb_card_sprite_blitter: directed and random blits against a reference write-list model
module tb_card_sprite_blitter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] sprite_id = '0;
  logic [9:0] dest_x = '0;
  logic [8:0] dest_y = '0;
  logic busy, done, fb_wen;
  logic [6:0] rom_addr;
  logic [8:0] rom_data = '0;
  logic [18:0] fb_addr;
  logic [8:0] fb_data;
  logic ready_dir = 1'b1, rnd_mode = 1'b0, rnd_bit = 1'b1, fb_ready;
  logic [8:0] rom_mem [128];
  int checks = 0, errors = 0, cyc = 0, ndone = 0, done_cyc = 0, e0 = 0;
  logic [27:0] wq[$], eq[$];

  assign fb_ready = rnd_mode ? rnd_bit : ready_dir;

  card_sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ROM_ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .sprite_id(sprite_id), .dest_x(dest_x),
    .dest_y(dest_y), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wen(fb_wen), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr];
    cyc <= cyc + 1;
    rnd_bit <= $urandom_range(0, 3) != 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (fb_wen && fb_ready) wq.push_back({fb_addr, fb_data});
      if (done) begin
        ndone <= ndone + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected writes in scan order: opaque pixels that land on screen
  function automatic void model(input int id, input int x, input int y);
    eq.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        logic [8:0] p;
        p = rom_mem[id * 8 + r * 4 + c];
        if (p != 9'h1FF && x + c < 640 && y + r < 480)
          eq.push_back({19'((y + r) * 640 + x + c), p});
      end
  endfunction

  task automatic go(input int id, input int x, input int y);
    model(id, x, y);
    wq.delete();
    ndone = 0;
    sprite_id = 4'(id);
    dest_x = 10'(x);
    dest_y = 9'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic finish_blit(input string tag, input int exp_lat);
    for (int i = 0; i < 300 && ndone == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_count"}, ndone, 1);
    if (exp_lat >= 0) check({tag, "_done_latency"}, done_cyc - e0, exp_lat);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_write_count"}, wq.size(), eq.size());
    for (int i = 0; i < wq.size() && i < eq.size(); i++) check({tag, "_write"}, wq[i], eq[i]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = $urandom_range(0, 4) == 0 ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int i = 0; i < 8; i++) begin
      rom_mem[8 + i] = 9'(i + 1);
      rom_mem[16 + i] = 9'(i + 1);
    end
    rom_mem[18] = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_wen", fb_wen, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    go(1, 10, 20);
    check("basic_busy", busy, 1);
    check("basic_rom_addr0", rom_addr, 8);
    finish_blit("basic", 10);
    check("basic_first", wq[0], {19'd12810, 9'd1});
    check("basic_row1", wq[4], {19'd13450, 9'd5});

    go(2, 10, 20);
    finish_blit("transp", 10);

    go(1, 638, 479);
    finish_blit("clip", 10);
    check("clip_n", wq.size(), 2);

    go(1, 10, 20);
    repeat (5) @(posedge clk);
    #1;
    ready_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_fb_addr", fb_addr, 12813);
      check("stall_fb_data", fb_data, 4);
      check("stall_fb_wen", fb_wen, 1);
      check("stall_rom_addr", rom_addr, 13);
    end
    ready_dir = 1'b1;
    finish_blit("stall", 13);

    go(1, 10, 20);
    repeat (3) @(posedge clk);
    #1;
    sprite_id = 4'd2;
    dest_x = 10'd0;
    dest_y = 9'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_blit("busy_start", 10);

    go(1, 10, 20);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_fb_wen", fb_wen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", ndone, 0);
    go(1, 10, 20);
    finish_blit("after_rst", 10);

    rnd_mode = 1'b1;
    for (int n = 0; n < 10; n++) begin
      int x, y;
      x = $urandom_range(0, 1) ? $urandom_range(0, 639) : $urandom_range(600, 1023);
      y = $urandom_range(0, 1) ? $urandom_range(0, 479) : $urandom_range(440, 511);
      go($urandom_range(0, 15), x, y);
      finish_blit("rand", -1);
    end
    rnd_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
